// File: rtl/key_expand_ctrl.sv
// AES-128 key schedule generator: emits the eleven round keys one at a time over a
// valid/ready handshake, computing each new key one word per cycle with one shared SubWord.

module key_expand_subword (
   input  logic [31:0] i_word,
   output logic [31:0] o_word
);

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box = affine(a^254); a^254 is the GF(2^8) inverse and maps 0 to 0
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = a;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                    sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

module key_expand_ctrl (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [0:127] key,
   output logic         busy,
   output logic [0:127] rk,
   output logic [3:0]   rk_round,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic         done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OUT  = 2'd1,
      S_CALC = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_w0, r_w1, r_w2, r_w3;
   logic [3:0]  r_round;
   logic [7:0]  r_rcon;
   logic [1:0]  r_wc;
   logic        r_done;
   logic [31:0] w_rot;
   logic [31:0] w_sub;
   logic        w_hs;
   logic        w_last;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
   endfunction

   // SubWord always sees RotWord(w3); its result only matters at wc=0
   assign w_rot = {r_w3[23:0], r_w3[31:24]};

   key_expand_subword u_subword (
      .i_word (w_rot),
      .o_word (w_sub)
   );

   assign w_hs   = (r_state == S_OUT) && rk_ready;
   assign w_last = (r_round == 4'd10);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b1;
      rk_valid    = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) w_state_nxt = S_OUT;
         end
         S_OUT: begin
            rk_valid = 1'b1;
            if (rk_ready) w_state_nxt = w_last ? S_IDLE : S_CALC;
         end
         S_CALC: begin
            if (r_wc == 2'd3) w_state_nxt = S_OUT;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_w0    <= 32'h0;
         r_w1    <= 32'h0;
         r_w2    <= 32'h0;
         r_w3    <= 32'h0;
         r_round <= 4'd0;
         r_rcon  <= 8'h01;
         r_wc    <= 2'd0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_hs && w_last;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_w0    <= key[0:31];
                  r_w1    <= key[32:63];
                  r_w2    <= key[64:95];
                  r_w3    <= key[96:127];
                  r_round <= 4'd0;
                  r_rcon  <= 8'h01;
                  r_wc    <= 2'd0;
               end
            end
            S_OUT: begin
               if (w_hs && !w_last) begin
                  r_round <= r_round + 4'd1;
                  r_wc    <= 2'd0;
               end
            end
            S_CALC: begin
               // in-place update: each word folds in its freshly updated predecessor
               case (r_wc)
                  2'd0: r_w0 <= r_w0 ^ w_sub ^ {r_rcon, 24'h0};
                  2'd1: r_w1 <= r_w1 ^ r_w0;
                  2'd2: r_w2 <= r_w2 ^ r_w1;
                  2'd3: begin
                     r_w3   <= r_w3 ^ r_w2;
                     r_rcon <= xtime(r_rcon);
                  end
                  default: ;
               endcase
               r_wc <= r_wc + 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign rk       = {r_w0, r_w1, r_w2, r_w3};
   assign rk_round = r_round;
   assign done     = r_done;

endmodule

// File: tb/tb_key_expand_ctrl.sv
// Bench for key_expand_ctrl: table of known-answer round keys, timing and corner-case
// sequences, and randomized keys/backpressure scored against a FIPS-197 schedule model.

module tb_key_expand_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] key;
   logic         busy;
   logic [127:0] rk;
   logic [3:0]   rk_round;
   logic         rk_valid;
   logic         rk_ready;
   logic         done;

   int n_checks = 0;
   int n_err    = 0;

   logic [127:0] mdl    [0:10];
   logic [127:0] got_rk [0:10];
   int           got_n  [0:10];

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   key_expand_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .key      (key),
      .busy     (busy),
      .rk       (rk),
      .rk_round (rk_round),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .done     (done)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [7:0] sb(input logic [7:0] x);
      return SBOX[2047 - 8*int'(x) -: 8];
   endfunction

   // Textbook 44-word expansion, then grouped into round keys
   task automatic model_expand(input logic [127:0] k);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
            rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++) mdl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out(input logic [3:0] r, input string nm);
      for (int i = 0; i < 200; i++) begin
         if (rk_valid && rk_round == r) return;
         tick();
      end
      chk(nm, 128'(0), 128'(1));
   endtask

   task automatic drain;
      rk_ready = 1'b1;
      start    = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (!busy && !done) return;
         tick();
      end
      chk("drain_timeout", 128'(0), 128'(1));
   endtask

   // Full expansion with rk_ready high; checks every key and its exact cycle
   task automatic run_expand(input logic [127:0] k);
      int done_n, done_cnt;
      model_expand(k);
      for (int r = 0; r <= 10; r++) begin
         got_rk[r] = '0;
         got_n[r]  = -1;
      end
      done_n   = -1;
      done_cnt = 0;
      rk_ready = 1'b1;
      key      = k;
      start    = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 1; n <= 56; n++) begin
         if (rk_valid && rk_round <= 4'd10 && got_n[rk_round] < 0) begin
            got_rk[rk_round] = rk;
            got_n[rk_round]  = n;
         end
         if (done) begin
            done_cnt++;
            if (done_n < 0) done_n = n;
         end
         tick();
      end
      for (int r = 0; r <= 10; r++) begin
         chk("run_rk", got_rk[r], mdl[r]);
         chk("run_latency", 128'(got_n[r]), 128'(1 + 5*r));
      end
      chk("run_done_cycle", 128'(done_n), 128'(52));
      chk("run_done_width", 128'(done_cnt), 128'(1));
      chk("run_idle_busy", 128'(busy), 128'(0));
   endtask

   typedef struct {
      logic [127:0] k;
      int           rnd;
      logic [127:0] exp;
   } vec_t;

   vec_t vecs [5];

   initial begin
      logic [127:0] k_fips, k_alt, k_rand, m10, hold_rk, got10;
      logic [3:0]   hold_rnd;
      logic         hold_v, stable, fin;
      int           exp_r, stab_err, n;

      k_fips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      k_alt  = 128'h000102030405060708090a0b0c0d0e0f;
      vecs[0] = '{k_fips, 0,  k_fips};
      vecs[1] = '{k_fips, 1,  128'ha0fafe1788542cb123a339392a6c7605};
      vecs[2] = '{k_fips, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vecs[3] = '{128'h0, 1,  128'h62636363626363636263636362636363};
      vecs[4] = '{128'h0, 2,  128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};

      // reset wins over a simultaneous start
      rst = 1'b1; start = 1'b1; key = k_fips; rk_ready = 1'b1;
      tick(); tick();
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_valid", 128'(rk_valid), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      chk("rst_rk", rk, 128'h0);
      chk("rst_round", 128'(rk_round), 128'(0));
      rst = 1'b0; start = 1'b0;
      tick();
      chk("idle_after_rst", 128'(busy), 128'(0));

      for (int i = 0; i < 5; i++) begin
         run_expand(vecs[i].k);
         chk("vec_rk", got_rk[vecs[i].rnd], vecs[i].exp);
      end

      // backpressure in round 3
      model_expand(k_fips);
      key = k_fips; start = 1'b1; rk_ready = 1'b1;
      tick();
      start = 1'b0;
      wait_out(4'd3, "bp_wait_timeout");
      rk_ready = 1'b0;
      hold_rk  = rk;
      stable   = 1'b1;
      repeat (20) begin
         tick();
         if (!rk_valid || rk !== hold_rk || rk_round !== 4'd3) stable = 1'b0;
      end
      chk("bp_stable", 128'(stable), 128'(1));
      chk("bp_rk3", hold_rk, mdl[3]);
      rk_ready = 1'b1;
      tick();
      tick(); tick(); tick();
      chk("bp_calc_no_valid", 128'(rk_valid), 128'(0));
      tick();
      chk("bp_valid_after5", 128'(rk_valid), 128'(1));
      chk("bp_round4", 128'(rk_round), 128'(4));
      chk("bp_rk4", rk, mdl[4]);
      drain();

      // start with a different key during round 5 calculation
      model_expand(k_fips);
      key = k_fips; start = 1'b1; rk_ready = 1'b1;
      tick();
      start = 1'b0;
      wait_out(4'd4, "ign_wait_timeout");
      tick();
      key = k_alt; start = 1'b1;
      tick(); tick();
      start = 1'b0;
      for (int r = 5; r <= 10; r++) begin
         wait_out(4'(r), "ign_round_timeout");
         chk("ign_rk", rk, mdl[r]);
      end
      tick();
      chk("ign_done", 128'(done), 128'(1));
      drain();

      // reset at wc=2 of round 4
      key = k_fips; start = 1'b1; rk_ready = 1'b1;
      tick();
      start = 1'b0;
      wait_out(4'd3, "mid_wait_timeout");
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      chk("mid_rst_rk", rk, 128'h0);
      chk("mid_rst_round", 128'(rk_round), 128'(0));
      chk("mid_rst_valid", 128'(rk_valid), 128'(0));
      chk("mid_rst_busy", 128'(busy), 128'(0));
      chk("mid_rst_done", 128'(done), 128'(0));
      rst = 1'b0;
      tick();
      run_expand(128'h0);
      chk("mid_fresh_r1", got_rk[1], 128'h62636363626363636263636362636363);

      // back-to-back with start held through done; key changed while busy
      model_expand(k_fips);
      m10 = mdl[10];
      got10 = '0;
      key = k_fips; start = 1'b1; rk_ready = 1'b1;
      tick();
      key = k_alt;
      n = 1;
      while (!done && n < 80) begin
         if (rk_valid && rk_round == 4'd10) got10 = rk;
         tick();
         n++;
      end
      chk("b2b_done_cycle", 128'(n), 128'(52));
      chk("b2b_first_r10", got10, m10);
      tick();
      chk("b2b_valid", 128'(rk_valid), 128'(1));
      chk("b2b_round0", 128'(rk_round), 128'(0));
      chk("b2b_rk0", rk, k_alt);
      start = 1'b0;
      model_expand(k_alt);
      tick();
      wait_out(4'd1, "b2b_r1_timeout");
      chk("b2b_rk1", rk, mdl[1]);
      drain();

      // random keys, random backpressure, random stray starts
      for (int t = 0; t < 4; t++) begin
         k_rand = {$urandom, $urandom, $urandom, $urandom};
         model_expand(k_rand);
         key = k_rand; start = 1'b1; rk_ready = 1'b0;
         tick();
         start    = 1'b0;
         exp_r    = 0;
         fin      = 1'b0;
         hold_v   = 1'b0;
         stab_err = 0;
         for (int c = 0; c < 800 && !fin; c++) begin
            if (hold_v && (!rk_valid || rk !== hold_rk || rk_round !== hold_rnd)) stab_err++;
            hold_v   = 1'b0;
            rk_ready = ($urandom_range(0, 2) != 0);
            start    = ($urandom_range(0, 3) == 0);
            key      = {$urandom, $urandom, $urandom, $urandom};
            if (rk_valid) begin
               if (rk_ready) begin
                  chk("rand_round", 128'(rk_round), 128'(exp_r));
                  chk("rand_rk", rk, mdl[exp_r]);
                  if (exp_r == 10) begin
                     fin   = 1'b1;
                     start = 1'b0;
                  end
                  exp_r++;
               end else begin
                  hold_v   = 1'b1;
                  hold_rk  = rk;
                  hold_rnd = rk_round;
               end
            end
            tick();
         end
         chk("rand_finished", 128'(fin), 128'(1));
         chk("rand_done", 128'(done), 128'(1));
         chk("rand_hold_stable", 128'(stab_err), 128'(0));
         start = 1'b0;
         tick();
         chk("rand_done_clear", 128'(done), 128'(0));
         chk("rand_idle", 128'(busy), 128'(0));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/key_expand_ctrl.md
KEY_EXPAND_CTRL -- requirements
Module: key_expand_ctrl

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to expand key; sampled only in IDLE.
REQ-005 SHALL have port key, input, [0:127], AES-128 cipher key; bit 0 is the MSB of byte 0, word 0 is [0:31].
REQ-006 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-007 SHALL have port rk, output, [0:127], current round key {w0,w1,w2,w3}.
REQ-008 SHALL have port rk_round, output, 4, index 0..10 of the key on rk.
REQ-009 SHALL have port rk_valid, output, 1, rk/rk_round valid; high only in OUT.
REQ-010 SHALL have port rk_ready, input, 1, consumer accepts rk when rk_valid&rk_ready.
REQ-011 SHALL have port done, output, 1, one-cycle pulse after round 10 is accepted.

Function
REQ-012 SHALL instantiate exactly one subword unit (4 Sbox) and time-share it; no other S-box logic.
REQ-013 SHALL implement states IDLE, OUT, CALC.
REQ-014 IDLE: start=1 -> latch key into w0..w3, round=0, rcon=8'h01, go to OUT next cycle; start=0 -> stay.
REQ-015 OUT: rk_valid=1; rk and rk_round SHALL hold stable until handshake.
REQ-016 OUT handshake with round<10 -> CALC, word counter wc=0, round incremented on CALC entry.
REQ-017 OUT handshake with round=10 -> IDLE; done=1 in the following cycle only.
REQ-018 CALC, one word per cycle, in-place: wc=0: w0 ^= SubWord(RotWord(w3)) ^ {rcon,24'h0}; wc=1: w1 ^= w0; wc=2: w2 ^= w1; wc=3: w3 ^= w2, then go to OUT.
REQ-019 RotWord SHALL be a left byte rotate: [a0,a1,a2,a3] -> [a1,a2,a3,a0].
REQ-020 subword input SHALL be RotWord(w3) at all times; its output used only at wc=0.
REQ-021 rcon SHALL update after wc=3: rcon<<1, XOR 8'h1b if old rcon[7]=1; round r uses 01,02,04,08,10,20,40,80,1b,36.
REQ-022 Latency: handshake in cycle N -> CALC cycles N+1..N+4 -> rk_valid=1 in cycle N+5; start in cycle S -> round-0 rk_valid=1 in cycle S+1.
REQ-023 Full expansion with rk_ready tied high SHALL take 1+10*5 cycles from start to final handshake, plus 1 to done.
REQ-024 start while busy SHALL be ignored and SHALL NOT alter key registers.
REQ-025 rk_ready while not in OUT SHALL be ignored.
REQ-026 rk SHALL reflect w0..w3 directly; its value during CALC is don't-care to consumers (rk_valid=0).
REQ-027 done and start in same cycle (IDLE): new expansion SHALL begin; done still pulses.

Reset
REQ-028 rst=1 SHALL force IDLE, w0..w3=0, rk=0, rk_round=0, rcon=8'h01, wc=0, rk_valid=0, busy=0, done=0, from any state including mid-CALC.
REQ-029 rst takes priority over start and rk_ready in the same cycle.

Verification
REQ-030 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> round0 = key, round1 = a0fafe1788542cb123a339392a6c7605, round10 = d014f9a8c9ee2589e13f0cc8b6630ca6, done at start+52.
REQ-031 Key all-zero -> round1 = 62636363626363636263636362636363, round2 = 9b9898c9f9fbfbaa9b9898c9f9fbfbaa.
REQ-032 Backpressure: rk_ready low 20 cycles in round 3 OUT -> rk, rk_round=3 stable, rk_valid held; next key correct 5 cycles after release.
REQ-033 start pulsed during CALC of round 5 with different key -> ignored; rounds 6..10 match original key's schedule.
REQ-034 rst asserted at wc=2 of round 4 -> next cycle all outputs zero, busy=0; fresh start gives correct round 1.
REQ-035 Back-to-back: start held high through done -> second expansion begins the cycle after return to IDLE, round0 rk_valid one cycle later, rcon restarted at 01.
